// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue/retire controller sitting between instruction fetch, the ALU and data memory.
// Optional memory-ack timeout is compiled in with `define MEM_TIMEOUT_EN (adds the mem_err output).
module alu_issue_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   input  logic [31:0] pc_in,
   output logic [4:0]  rs_addr,
   output logic [4:0]  rt_addr,
   output logic [4:0]  alu_control_signal,
   output logic        alu_imm_sel,
   output logic [31:0] imm_ext,
   output logic [31:0] shamt_out,
   input  logic [31:0] alu_out,
   input  logic [4:0]  flags,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   output logic        reg_we,
   output logic [4:0]  reg_waddr,
   output logic        wb_sel,
   output logic        pc_load,
   output logic [31:0] pc_target,
   output logic        done,
   output logic        illegal,
`ifdef MEM_TIMEOUT_EN
   output logic        mem_err,
`endif
   output logic        carry_q
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;

   logic [2:0]  state_reg, state_next;
   logic [31:0] instr_reg;
   logic [31:0] pc_reg;
   logic [31:0] alu_res_reg;
   logic        carry_reg;

   logic [5:0]  opcode;
   logic [4:0]  rs_f, rt_f, shamt_f, func_f;
   logic [31:0] imm_sext;

   assign opcode   = instr_reg[31:26];
   assign rs_f     = instr_reg[25:21];
   assign rt_f     = instr_reg[20:16];
   assign shamt_f  = instr_reg[15:11];
   assign func_f   = instr_reg[4:0];
   assign imm_sext = {{16{instr_reg[15]}}, instr_reg[15:0]};

   logic [4:0] dec_code;
   logic       dec_imm, dec_bad, dec_mem, dec_store, dec_write;
   logic       dec_dst_rt, dec_load, dec_branch, dec_carry;
   logic       br_taken;
   logic       tmo_hit;

   always_comb begin
      dec_code   = 5'd0;
      dec_imm    = 1'b0;
      dec_bad    = 1'b0;
      dec_mem    = 1'b0;
      dec_store  = 1'b0;
      dec_write  = 1'b0;
      dec_dst_rt = 1'b0;
      dec_load   = 1'b0;
      dec_branch = 1'b0;
      dec_carry  = 1'b0;
      case (opcode)
         6'd0: begin
            dec_code  = func_f;
            dec_write = 1'b1;
            dec_carry = (func_f == 5'd0);
            dec_bad   = !((func_f <= 5'd9) || (func_f == 5'd16));
         end
         6'd1: begin
            dec_imm   = 1'b1;
            dec_write = 1'b1;
            dec_carry = 1'b1;
         end
         6'd2: begin
            dec_code  = 5'd1;
            dec_imm   = 1'b1;
            dec_write = 1'b1;
         end
         6'd3: begin
            dec_imm    = 1'b1;
            dec_mem    = 1'b1;
            dec_write  = 1'b1;
            dec_dst_rt = 1'b1;
            dec_load   = 1'b1;
         end
         6'd4: begin
            dec_imm   = 1'b1;
            dec_mem   = 1'b1;
            dec_store = 1'b1;
         end
         6'd5: begin
            // ALU passes rs through; the condition is resolved in WB from the registered result
            dec_branch = 1'b1;
            dec_bad    = (rt_f > 5'd4);
            dec_code   = 5'd11 + rt_f;
         end
         6'd6: begin
            dec_code   = 5'd10;
            dec_branch = 1'b1;
         end
         default: dec_bad = 1'b1;
      endcase
   end

   always_comb begin
      br_taken = 1'b0;
      if (opcode == 6'd6) begin
         br_taken = 1'b1;
      end else begin
         case (rt_f)
            5'd0:    br_taken = alu_res_reg[31];
            5'd1:    br_taken = (alu_res_reg != 32'd0);
            5'd2:    br_taken = (alu_res_reg == 32'd0);
            5'd3:    br_taken = carry_reg;
            5'd4:    br_taken = !carry_reg;
            default: br_taken = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (instr_valid) state_next = S_DECODE;
         S_DECODE: state_next = dec_bad ? S_IDLE : S_EXEC;
         S_EXEC:   state_next = dec_mem ? S_MEM : S_WB;
         S_MEM: begin
            if (mem_ack) state_next = S_WB;
            else if (tmo_hit) state_next = S_IDLE;
         end
         S_WB:     state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         instr_reg   <= 32'd0;
         pc_reg      <= 32'd0;
         alu_res_reg <= 32'd0;
         carry_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_IDLE && instr_valid) begin
            instr_reg <= instr;
            pc_reg    <= pc_in;
         end
         if (state_reg == S_EXEC) begin
            alu_res_reg <= alu_out;
            if (dec_carry) carry_reg <= flags[4];
         end
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   logic [TW-1:0] tmo_cnt_reg;
   logic          mem_err_reg;

   // an ack arriving on the last allowed cycle still completes the access
   assign tmo_hit = (state_reg == S_MEM) && !mem_ack && (tmo_cnt_reg == TW'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_reg <= '0;
         mem_err_reg <= 1'b0;
      end else begin
         mem_err_reg <= tmo_hit;
         if (state_reg == S_MEM) tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
         else tmo_cnt_reg <= '0;
      end
   end

   assign mem_err = mem_err_reg;
`else
   assign tmo_hit = 1'b0;
`endif

   logic unused_bits;
   assign unused_bits = ^{flags[3:0], (MEM_TIMEOUT > 0)};

   logic in_dx, in_wb, in_mem;
   assign in_dx  = (state_reg == S_DECODE) || (state_reg == S_EXEC);
   assign in_wb  = (state_reg == S_WB);
   assign in_mem = (state_reg == S_MEM);

   assign instr_ready        = (state_reg == S_IDLE);
   assign rs_addr            = in_dx ? rs_f : 5'd0;
   assign rt_addr            = in_dx ? rt_f : 5'd0;
   assign alu_control_signal = in_dx ? dec_code : 5'd0;
   assign alu_imm_sel        = in_dx && dec_imm;
   assign imm_ext            = in_dx ? imm_sext : 32'd0;
   assign shamt_out          = in_dx ? {27'd0, shamt_f} : 32'd0;

   assign mem_req  = in_mem;
   assign mem_we   = in_mem && dec_store;
   assign mem_addr = in_mem ? alu_res_reg : 32'd0;

   assign reg_we    = in_wb && dec_write;
   assign reg_waddr = (in_wb && dec_write) ? (dec_dst_rt ? rt_f : rs_f) : 5'd0;
   assign wb_sel    = in_wb && dec_load;
   assign pc_load   = in_wb && dec_branch && br_taken;
   assign pc_target = pc_load ? (pc_reg + 32'd1 + imm_sext) : 32'd0;
   assign done      = in_wb;
   assign illegal   = (state_reg == S_DECODE) && dec_bad;
   assign carry_q   = carry_reg;

endmodule
